// File: rtl/spike_fifo_bank.sv
// rtl/spike_fifo_bank.sv - multi-channel spike FIFO bank with round-robin drain
//
// Each of N_CH channels queues {neuron address, arrival stamp} entries pushed by
// the time-multiplexed neuron array. A round-robin arbiter drains the channels
// into a single registered valid/ready output.
//
// Optional feature: define SPIKE_FIFO_DROP_CNT_EN to build the saturating
// dropped-push counter; otherwise drop_cnt is tied to zero.
//
// Ports:
//   CLK, RST_N           clock, asynchronous active-low reset
//   flush                synchronous clear of FIFOs, output register, arbiter
//   spike[N_CH]          per-channel push request
//   mux_idx              current multiplex index
//   base_addr            per-channel address offset (N_CH x ADDR_DW)
//   stamp_now, delay     current stamp and per-channel delay (N_CH x STAMP_DW)
//   out_valid/out_ready  output handshake
//   out_addr/out_stamp/out_ch  output entry and its source channel
//   empty_vec, full_vec  per-channel status
//   head_addr            per-channel head address, all-ones when empty
//   drop_cnt             rejected-push count
module spike_fifo_bank #(
  parameter int N_CH     = 16,
  parameter int DEPTH    = 64,
  parameter int MUX_DW   = 10,
  parameter int ADDR_DW  = 14,
  parameter int STAMP_DW = 4,
  parameter int CW       = $clog2(N_CH)
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       flush,
  input  logic [N_CH-1:0]            spike,
  input  logic [MUX_DW-1:0]          mux_idx,
  input  logic [N_CH*ADDR_DW-1:0]    base_addr,
  input  logic [STAMP_DW-1:0]        stamp_now,
  input  logic [N_CH*STAMP_DW-1:0]   delay,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_DW-1:0]         out_addr,
  output logic [STAMP_DW-1:0]        out_stamp,
  output logic [CW-1:0]              out_ch,
  output logic [N_CH-1:0]            empty_vec,
  output logic [N_CH-1:0]            full_vec,
  output logic [N_CH*ADDR_DW-1:0]    head_addr,
  output logic [15:0]                drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = ADDR_DW + STAMP_DW;

  logic [EW-1:0]       mem    [N_CH][DEPTH];
  logic [AW:0]         cnt    [N_CH];
  logic [AW-1:0]       wr_ptr [N_CH];
  logic [AW-1:0]       rd_ptr [N_CH];
  logic [CW-1:0]       last_grant;

  logic [ADDR_DW-1:0]  push_addr  [N_CH];
  logic [STAMP_DW-1:0] push_stamp [N_CH];
  logic [N_CH-1:0]     push_ok;
  logic [N_CH-1:0]     pop;
  logic                load;
  logic                gnt_found;
  logic [CW-1:0]       gnt_ch;
  logic [EW-1:0]       gnt_entry;

  // Entry formation and per-channel status (status is pure registered state).
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      push_addr[i]  = base_addr[i*ADDR_DW +: ADDR_DW]
                    + ADDR_DW'({mux_idx, {CW{1'b0}}})
                    + ADDR_DW'(i);
      push_stamp[i] = stamp_now + delay[i*STAMP_DW +: STAMP_DW];
      empty_vec[i]  = (cnt[i] == '0);
      full_vec[i]   = (cnt[i] == (AW+1)'(DEPTH));
      // Full is judged on the pre-edge count, so a same-cycle pop does not help.
      push_ok[i]    = spike[i] && !full_vec[i];
      head_addr[i*ADDR_DW +: ADDR_DW] = empty_vec[i] ? {ADDR_DW{1'b1}}
                                                     : mem[i][rd_ptr[i]][EW-1 -: ADDR_DW];
    end
  end

  // Round-robin arbiter: search starts one past the last grant and wraps.
  always_comb begin
    logic [CW-1:0] idx;
    load      = !out_valid || out_ready;
    gnt_found = 1'b0;
    gnt_ch    = '0;
    idx       = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = last_grant + CW'(k);
      if (!gnt_found && !empty_vec[idx]) begin
        gnt_found = 1'b1;
        gnt_ch    = idx;
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      pop[i] = load && gnt_found && (gnt_ch == CW'(i));
    end
    gnt_entry = mem[gnt_ch][rd_ptr[gnt_ch]];
  end

  // Storage array carries no reset; validity is tracked by the counts.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < N_CH; i++) begin
      if (push_ok[i] && !flush) begin
        mem[i][wr_ptr[i]] <= {push_addr[i], push_stamp[i]};
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt[i]    <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      last_grant <= CW'(N_CH - 1);
      out_valid  <= 1'b0;
      out_addr   <= '0;
      out_stamp  <= '0;
      out_ch     <= '0;
    end else if (flush) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt[i]    <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      last_grant <= CW'(N_CH - 1);
      out_valid  <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])     rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({push_ok[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + 1'b1;
          2'b01:   cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
      if (load) begin
        if (gnt_found) begin
          out_valid  <= 1'b1;
          out_addr   <= gnt_entry[EW-1 -: ADDR_DW];
          out_stamp  <= gnt_entry[STAMP_DW-1:0];
          out_ch     <= gnt_ch;
          last_grant <= gnt_ch;
        end else begin
          out_valid  <= 1'b0;
        end
      end
    end
  end

`ifdef SPIKE_FIFO_DROP_CNT_EN
  logic [CW:0]  n_drop;
  logic [16:0]  drop_sum;

  always_comb begin
    n_drop = '0;
    for (int i = 0; i < N_CH; i++) begin
      n_drop = n_drop + (CW+1)'(spike[i] && full_vec[i]);
    end
    drop_sum = {1'b0, drop_cnt} + 17'(n_drop);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      drop_cnt <= '0;
    end else if (flush) begin
      drop_cnt <= '0;
    end else begin
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_spike_fifo_bank.sv
// tb/tb_spike_fifo_bank.sv - scoreboard bench for spike_fifo_bank
module tb_spike_fifo_bank;

  localparam int N_CH = 16, DEPTH = 64, MUX_DW = 10, ADDR_DW = 14, STAMP_DW = 4, CW = 4;

  logic                     CLK = 1'b0;
  logic                     RST_N;
  logic                     flush;
  logic [N_CH-1:0]          spike;
  logic [MUX_DW-1:0]        mux_idx;
  logic [N_CH*ADDR_DW-1:0]  base_addr;
  logic [STAMP_DW-1:0]      stamp_now;
  logic [N_CH*STAMP_DW-1:0] delay;
  logic                     out_valid;
  logic                     out_ready;
  logic [ADDR_DW-1:0]       out_addr;
  logic [STAMP_DW-1:0]      out_stamp;
  logic [CW-1:0]            out_ch;
  logic [N_CH-1:0]          empty_vec;
  logic [N_CH-1:0]          full_vec;
  logic [N_CH*ADDR_DW-1:0]  head_addr;
  logic [15:0]              drop_cnt;

  spike_fifo_bank #(.N_CH(N_CH), .DEPTH(DEPTH), .MUX_DW(MUX_DW),
                    .ADDR_DW(ADDR_DW), .STAMP_DW(STAMP_DW)) dut (
    .CLK(CLK), .RST_N(RST_N), .flush(flush), .spike(spike), .mux_idx(mux_idx),
    .base_addr(base_addr), .stamp_now(stamp_now), .delay(delay),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_stamp(out_stamp), .out_ch(out_ch), .empty_vec(empty_vec),
    .full_vec(full_vec), .head_addr(head_addr), .drop_cnt(drop_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct { int addr; int stamp; int ch; } exp_t;
  exp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected entry built from the arithmetic definition, independent of the RTL.
  task automatic push_exp(input int ch, input int base, input int mux, input int sn, input int dl);
    exp_t e;
    e.addr  = (base + mux * 16 + ch) % 16384;
    e.stamp = (sn + dl) % 16;
    e.ch    = ch;
    exp_q.push_back(e);
  endtask

  task automatic set_ch(input int ch, input int base, input int dl);
    base_addr[ch*ADDR_DW +: ADDR_DW] = ADDR_DW'(base);
    delay[ch*STAMP_DW +: STAMP_DW]   = STAMP_DW'(dl);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  // Monitor: every accepted output must match the scoreboard head.
  always @(negedge CLK) begin
    if (RST_N && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: got ch %0d addr %0d, expected no output", out_ch, out_addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_addr", out_addr, e.addr);
        chk("out_stamp", out_stamp, e.stamp);
        chk("out_ch", out_ch, e.ch);
      end
    end
  end

  initial begin
    RST_N = 1'b0; flush = 1'b0; spike = '0; mux_idx = '0;
    base_addr = '0; stamp_now = '0; delay = '0; out_ready = 1'b1;
    repeat (3) tick();
    RST_N = 1'b1;
    tick();

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_empty_vec", empty_vec, 16'hFFFF);
    chk("rst_full_vec", full_vec, 0);
    chk("rst_head_all_ones", &head_addr, 1);
    chk("rst_drop_cnt", drop_cnt, 0);

    // Single spike: 100 + (3<<4) + 0 = 148, stamp 2+5 = 7, two-edge latency
    set_ch(0, 100, 5);
    spike = 16'h0001; mux_idx = 3; stamp_now = 2;
    push_exp(0, 100, 3, 2, 5);
    tick();
    spike = '0;
    chk("t1_empty0", empty_vec[0], 0);
    chk("t1_head0", head_addr[0 +: ADDR_DW], 148);
    chk("t1_no_bypass", out_valid, 0);
    tick();
    chk("t1_valid", out_valid, 1);
    tick();
    chk("t1_valid_clear", out_valid, 0);
    chk("t1_drained", exp_q.size(), 0);

    // All 16 channels at once: round-robin 0..15, one per cycle
    do_flush();
    mux_idx = 2; stamp_now = 1;
    for (int i = 0; i < N_CH; i++) begin
      set_ch(i, i * 100, i);
      push_exp(i, i * 100, 2, 1, i);
    end
    spike = '1;
    tick();
    spike = '0;
    repeat (16) tick();
    chk("t2_throughput_left", exp_q.size(), 1);
    wait_drain("t2_drain");

    // Fill channel 5 with out_ready low: one entry in the output register, 64 in the FIFO
    do_flush();
    out_ready = 1'b0;
    set_ch(5, 200, 1);
    for (int k = 0; k < 66; k++) begin
      spike = 16'h0020; mux_idx = MUX_DW'(k); stamp_now = STAMP_DW'(k % 16);
      if (k < 65) push_exp(5, 200, k, k % 16, 1);
      tick();
      if (k == 63) chk("t3_not_full_64", full_vec[5], 0);
      if (k == 64) chk("t3_full_65", full_vec[5], 1);
    end
    spike = '0;
`ifdef SPIKE_FIFO_DROP_CNT_EN
    chk("t3_drop_cnt", drop_cnt, 1);
`else
    chk("t3_drop_cnt", drop_cnt, 0);
`endif
    // Stall: output held and no count change
    for (int c = 0; c < 5; c++) begin
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_addr", out_addr, 205);
      chk("t3_hold_stamp", out_stamp, 1);
      chk("t3_hold_ch", out_ch, 5);
      chk("t3_hold_full", full_vec[5], 1);
      tick();
    end
    out_ready = 1'b1;
    wait_drain("t3_drain");

    // Wrap cases: stamp 15+3 -> 2, address 16383+0+1 -> 0
    do_flush();
    set_ch(1, 16383, 3);
    spike = 16'h0002; mux_idx = 0; stamp_now = 15;
    push_exp(1, 16383, 0, 15, 3);
    tick();
    spike = '0;
    wait_drain("t4_drain");

    // Flush mid-drain of channels 2 and 9
    do_flush();
    set_ch(2, 1000, 0);
    set_ch(9, 2000, 0);
    for (int k = 0; k < 4; k++) begin
      spike = 16'h0204; mux_idx = MUX_DW'(k); stamp_now = STAMP_DW'(k);
      push_exp(2, 1000, k, k, 0);
      push_exp(9, 2000, k, k, 0);
      tick();
    end
    spike = '0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
    chk("t5_flush_empty", empty_vec, 16'hFFFF);
    chk("t5_flush_valid", out_valid, 0);
    chk("t5_flush_head", &head_addr, 1);
    tick();
    chk("t5_flush_still_empty", empty_vec, 16'hFFFF);

    // Asynchronous reset mid-drain
    for (int k = 0; k < 3; k++) begin
      spike = 16'h0204; mux_idx = MUX_DW'(k); stamp_now = STAMP_DW'(k);
      push_exp(2, 1000, k, k, 0);
      push_exp(9, 2000, k, k, 0);
      tick();
    end
    spike = '0;
    #2;
    RST_N = 1'b0;
    #1;
    exp_q.delete();
    chk("t6_rst_empty", empty_vec, 16'hFFFF);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_head", &head_addr, 1);
    chk("t6_rst_out_addr", out_addr, 0);
    tick();
    RST_N = 1'b1;
    tick();
    chk("t6_after_rst_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
